bcd_converter: RTL and testbench
================================

# bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the 16x16 multiplier. It takes the 32-bit unsigned product (or any 32-bit result) and produces 10 packed BCD digits plus a significant-digit count for the display/digit-select stage. It uses iterative shift-add-3 (double dabble), one bit per clock, with a start/busy/done handshake.

## Interface
Parameters:
- IN_WIDTH, 32: binary input width. The only supported value is 32.
- DIGITS, 10: number of BCD digits. It must satisfy 10^DIGITS > 2^IN_WIDTH − 1.

Ports:
- clk  input  1  system clock. Every register updates on the rising edge.
- rst_n  input  1  reset. It is synchronous and active-low: sampled on the rising edge of clk, with 0 meaning reset.
- start  input  1  conversion request. It is sampled only when busy = 0.
- bin_in  input  32  unsigned binary value. It is sampled only on the edge where start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse marking that bcd_out and num_digits are valid and freshly updated.
- bcd_out  output  40  packed BCD. Digit k occupies bits [4k+3:4k], and digit 0 is the ones digit.
- num_digits  output  4  count of significant digits, 1..10. A value of 0 reports 1.

## Operation
- Internal state:
  - 32-bit binary shift register.
  - 40-bit BCD working register.
  - 5-bit iteration counter.
  - state ∈ {IDLE, SHIFT}.
- IDLE:
  - If start = 1, then:
    - load the binary register with bin_in;
    - clear the BCD working register and the counter;
    - go to SHIFT.
  - Otherwise, hold.
- SHIFT: each cycle performs one iteration.
  1. Correct: for every working digit ≥ 5, add 3 to it (4-bit add, no carry out of the digit).
  2. Shift: shift {corrected BCD, binary} left by 1.
  3. Advance the counter by 1.
  - On the iteration where counter = 31 (the 32nd iteration):
    - load bcd_out with the post-shift BCD value;
    - load num_digits with (index of the most significant nonzero digit) + 1, or 1 if all digits are zero;
    - set done = 1;
    - return to IDLE.
- bcd_out and num_digits hold their value until the next completed conversion. A conversion in progress never disturbs them.
- start while busy = 1 is ignored. The conversion in flight and bin_in changes have no effect.
- start in the done cycle (state IDLE, busy = 0) is accepted as a new conversion.
- Reset (rst_n = 0 at an edge), including mid-conversion:
  - state returns to IDLE, busy = 0, done = 0;
  - bcd_out = 0, num_digits = 1, counter and working registers = 0;
  - no done pulse is emitted for the aborted conversion.
- Arithmetic:
  - Unsigned only.
  - The maximum input 0xFFFFFFFF = 4294967295 fits in 10 digits, so no overflow is possible.
  - Digit 9 never exceeds 4.

## Timing
- Start is accepted at edge N: busy = 1 from edge N through edge N+31.
- At edge N+32: busy = 0, done = 1, bcd_out and num_digits are valid.
- At edge N+33: done = 0, unless that cycle itself completes a conversion, which is impossible.
- Latency from start acceptance to done is 32 cycles.
- Maximum throughput is one conversion per 33 cycles (start held high continuously).
- done and busy are never high in the same cycle.
- All outputs are registered. There is no combinational path from start or bin_in to any output.

## Test plan
- Reset, then bin_in = 0 with start pulse:
  - after 32 cycles, done pulses once;
  - bcd_out = 40'h00_0000_0000, num_digits = 1.
- bin_in = 32'd12345:
  - bcd_out = 40'h00_0001_2345, num_digits = 5;
  - busy is high for exactly 32 cycles.
- bin_in = 32'hFFFE0001 (0xFFFF × 0xFFFF from the multiplier): bcd_out = 40'h42_9483_6225, num_digits = 10.
- bin_in = 32'hFFFFFFFF with start held high continuously:
  - bcd_out = 40'h42_9496_7295;
  - done pulses every 33 cycles;
  - changing bin_in to 7 mid-conversion does not alter the in-flight result;
  - the next result is 40'h7, num_digits = 1.
- Start 999 with a second start pulse (bin_in = 5) while busy:
  - the second pulse is ignored;
  - result is 40'h999, num_digits = 3.
- Reset asserted at iteration 10 of a conversion of 12345:
  - outputs become busy = 0, done = 0, bcd_out = 0, num_digits = 1;
  - no done pulse follows;
  - a fresh start of 100 yields 40'h100.

Source files
------------

// File: rtl/bcd_if.sv
//------------------------------------------------------------------------------
// bcd_if
// Handshake and result bundle between the binary producer (multiplier side)
// and the bcd_converter.
//   start       producer -> converter  conversion request
//   bin_in      producer -> converter  unsigned binary value
//   busy        converter -> producer  conversion in progress
//   done        converter -> producer  one-cycle result-valid pulse
//   bcd_out     converter -> producer  packed BCD, digit 0 in bits [3:0]
//   num_digits  converter -> producer  count of significant digits (1..DIGITS)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface bcd_if #(
    parameter int IN_WIDTH = 32,
    parameter int DIGITS   = 10
);
    logic                  start;
    logic [IN_WIDTH-1:0]   bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [3:0]            num_digits;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, num_digits
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, num_digits
    );
endinterface

// File: rtl/bcd_converter.sv
//------------------------------------------------------------------------------
// bcd_converter
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// A conversion takes IN_WIDTH cycles in SHIFT; the result is registered into
// bcd_out/num_digits together with a one-cycle done pulse.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    bcd_if.slave: start/bin_in in, busy/done/bcd_out/num_digits out
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module bcd_converter #(
    parameter int IN_WIDTH = 32,
    parameter int DIGITS   = 10
) (
    input  logic  clk,
    input  logic  rst_n,
    bcd_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IN_WIDTH-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]     work_q, work_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [BCD_W-1:0]     out_q, out_d;
    logic [3:0]           ndig_q, ndig_d;

    // Add 3 to every digit that is 5 or more, so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3_correct(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Position of the most significant nonzero digit plus one; an all-zero
    // value still reports a single digit.
    function automatic logic [3:0] sig_digits(input logic [BCD_W-1:0] v);
        logic [3:0] n;
        n = 4'd1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] != 4'd0) begin
                n = 4'(k + 1);
            end
        end
        return n;
    endfunction

    always_comb begin
        logic [BCD_W+IN_WIDTH-1:0] joint;

        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        out_d   = out_q;
        ndig_d  = ndig_q;
        joint   = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_d   = bus.bin_in;
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                joint  = {add3_correct(work_q), bin_q} << 1;
                work_d = joint[BCD_W+IN_WIDTH-1 : IN_WIDTH];
                bin_d  = joint[IN_WIDTH-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
                    // Final iteration: publish the post-shift value directly.
                    out_d   = work_d;
                    ndig_d  = sig_digits(work_d);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
            ndig_q  <= 4'd1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            out_q   <= out_d;
            ndig_q  <= ndig_d;
        end
    end

    // busy is a decode of the state register, so it stays glitch-free and
    // is never high together with done (done is only set on leaving SHIFT).
    assign bus.busy       = (state_q == SHIFT);
    assign bus.done       = done_q;
    assign bus.bcd_out    = out_q;
    assign bus.num_digits = ndig_q;

endmodule

// File: tb/tb_bcd_converter.sv
`timescale 1ns/1ps
module tb_bcd_converter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_seen = 0;

    logic [43:0] sb[$];

    bcd_if #(.IN_WIDTH(32), .DIGITS(10)) bus ();

    bcd_converter #(.IN_WIDTH(32), .DIGITS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: repeated division by ten, independent of shift-add-3.
    function automatic logic [43:0] model(input logic [31:0] v);
        logic [39:0] b;
        logic [3:0]  n;
        logic [31:0] x;
        b = '0;
        n = 4'd1;
        x = v;
        for (int k = 0; k < 10; k++) begin
            b[4*k +: 4] = 4'(x % 10);
            if ((x % 10) != 0) n = 4'(k + 1);
            x = x / 10;
        end
        return {n, b};
    endfunction

    // Acceptance tracker: a start seen while idle and out of reset is a new job.
    always @(posedge clk) begin
        if (rst_n && bus.start && !bus.busy) begin
            sb.push_back(model(bus.bin_in));
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        if (bus.done) begin
            done_seen++;
            check("busy_with_done", {63'b0, bus.busy}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", {63'b0, bus.done}, 64'd0);
            end else begin
                logic [43:0] e;
                e = sb.pop_front();
                check("bcd_out", {24'b0, bus.bcd_out}, {24'b0, e[39:0]});
                check("num_digits", {60'b0, bus.num_digits}, {60'b0, e[43:40]});
            end
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) return;
            lat++;
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    // One pulse conversion with busy-length check.
    task automatic run_one(input logic [31:0] v);
        int lat;
        @(negedge clk);
        bus.bin_in = v;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done(lat);
        check("busy_cycles", 64'(lat + 1), 64'd32);
    endtask

    initial begin
        int lat;
        int t1;
        int d0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);
        check("rst_bcd", {24'b0, bus.bcd_out}, 64'd0);
        check("rst_ndig", {60'b0, bus.num_digits}, 64'd1);
        rst_n = 1'b1;

        run_one(32'd0);
        check("zero_bcd", {24'b0, bus.bcd_out}, 64'h0);
        run_one(32'd12345);
        check("12345_bcd", {24'b0, bus.bcd_out}, 64'h00_0001_2345);
        check("12345_ndig", {60'b0, bus.num_digits}, 64'd5);
        run_one(32'hFFFE0001);
        check("sq_bcd", {24'b0, bus.bcd_out}, 64'h42_9483_6225);
        check("sq_ndig", {60'b0, bus.num_digits}, 64'd10);

        // Start held high: back-to-back conversions, bin_in changed mid-flight.
        @(negedge clk);
        bus.bin_in = 32'hFFFFFFFF;
        bus.start  = 1'b1;
        repeat (10) @(negedge clk);
        bus.bin_in = 32'd7;
        wait_done(lat);
        t1 = cyc;
        check("max_bcd", {24'b0, bus.bcd_out}, 64'h42_9496_7295);
        check("max_ndig", {60'b0, bus.num_digits}, 64'd10);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check("period", 64'(cyc - t1), 64'd33);
        check("seven_bcd", {24'b0, bus.bcd_out}, 64'h7);
        check("seven_ndig", {60'b0, bus.num_digits}, 64'd1);

        // Start while busy is ignored.
        @(negedge clk);
        bus.bin_in = 32'd999;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (5) @(negedge clk);
        bus.bin_in = 32'd5;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done(lat);
        check("999_bcd", {24'b0, bus.bcd_out}, 64'h999);
        check("999_ndig", {60'b0, bus.num_digits}, 64'd3);
        repeat (40) @(negedge clk);
        check("ignored_start_queue", 64'(sb.size()), 64'd0);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bus.bin_in = 32'd12345;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_busy", {63'b0, bus.busy}, 64'd0);
        check("mid_rst_done", {63'b0, bus.done}, 64'd0);
        check("mid_rst_bcd", {24'b0, bus.bcd_out}, 64'd0);
        check("mid_rst_ndig", {60'b0, bus.num_digits}, 64'd1);
        rst_n = 1'b1;
        d0 = done_seen;
        repeat (40) @(negedge clk);
        check("no_done_after_rst", 64'(done_seen - d0), 64'd0);
        run_one(32'd100);
        check("100_bcd", {24'b0, bus.bcd_out}, 64'h100);
        check("100_ndig", {60'b0, bus.num_digits}, 64'd3);

        // A few random values against the division model.
        for (int i = 0; i < 6; i++) begin
            run_one($urandom);
        end
        run_one(32'd1000000000);
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
